// File: rtl/kanagawa_dot_seq_pkg.sv
// Shared types for the dot-product sequencer: tag pipeline entries and result FIFO words.
// Count fields are sized for the widest supported CNT_W (32); narrower counters zero-extend.
package kanagawa_dot_seq_pkg;

   localparam int FP32_W        = 32;
   localparam int DOT_CNT_MAX_W = 32;

   typedef struct packed {
      logic                     valid;
      logic                     last;
      logic [DOT_CNT_MAX_W-1:0] count;
   } dot_tag_t;

   typedef struct packed {
      logic [FP32_W-1:0]        result;
      logic [DOT_CNT_MAX_W-1:0] count;
   } dot_result_t;

endpackage

// File: rtl/kanagawa_dot_seq_result_fifo.sv
// Registered first-word-fall-through FIFO for finished dot products.
// The head entry is read straight from storage, so it holds steady while stalled.
module kanagawa_dot_seq_result_fifo
   import kanagawa_dot_seq_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  dot_result_t in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output dot_result_t out_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   dot_result_t   mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          wr, rd;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign in_ready  = (cnt_q < CW'(DEPTH));
   assign out_valid = (cnt_q != '0);
   assign wr        = in_valid && in_ready;
   assign rd        = out_valid && out_ready;
   assign out_data  = mem_q[rd_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr) begin
            mem_q[wr_q] <= in_data;
            wr_q        <= bump(wr_q);
         end
         if (rd) rd_q <= bump(rd_q);
         if (wr && !rd)      cnt_q <= cnt_q + CW'(1);
         else if (!wr && rd) cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/kanagawa_dot_accum_sequencer.sv
// Streams fp32 operand pairs into an unstallable fmac32 and collects one dot product per vector.
// Build option: KANAGAWA_DOT_SEQ_COUNT_EN enables per-vector element counting (CNT_W <= 32).
module kanagawa_dot_accum_sequencer
   import kanagawa_dot_seq_pkg::*;
#(
   parameter int LATENCY   = 4,
   parameter int OUT_DEPTH = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_x,
   input  logic [31:0]      in_y,
   input  logic             in_last,
   output logic [31:0]      mac_x_out,
   output logic [31:0]      mac_y_out,
   output logic             mac_accumulate_out,
   output logic             mac_valid_out,
   input  logic [31:0]      mac_result_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [CNT_W-1:0] out_count
);

   localparam int OW = $clog2(OUT_DEPTH + 1);

   logic                     accept, last_acc, pop;
   logic                     first_q;
   logic [OW-1:0]            outst_q, outst_d;
   dot_tag_t                 tag_q [LATENCY+1];
   logic [DOT_CNT_MAX_W-1:0] cnt_tag;
   dot_result_t              fifo_wdata, fifo_rdata;
   logic                     fifo_wr, fifo_ready_unused, cnt_unused;

   // Credits cover every result the MAC will ever deliver, so the FIFO cannot overflow.
   assign in_ready = !rst && (outst_q < OW'(OUT_DEPTH));
   assign accept   = in_valid && in_ready;
   assign last_acc = accept && in_last;
   assign pop      = out_valid && out_ready;

   always_comb begin
      outst_d = outst_q;
      if (last_acc && !pop)      outst_d = outst_q + OW'(1);
      else if (!last_acc && pop) outst_d = outst_q - OW'(1);
   end

`ifdef KANAGAWA_DOT_SEQ_COUNT_EN
   logic [CNT_W-1:0] elem_q, elem_inc;

   assign elem_inc  = (elem_q == {CNT_W{1'b1}}) ? elem_q : elem_q + CNT_W'(1);
   assign cnt_tag   = DOT_CNT_MAX_W'(elem_inc);
   assign out_count = fifo_rdata.count[CNT_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         elem_q <= '0;
      else if (accept) elem_q <= in_last ? '0 : elem_inc;
   end
`else
   assign cnt_tag   = '0;
   assign out_count = '0;
`endif
   assign cnt_unused = ^fifo_rdata.count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_q            <= 1'b1;
         outst_q            <= '0;
         mac_x_out          <= '0;
         mac_y_out          <= '0;
         mac_accumulate_out <= 1'b0;
         mac_valid_out      <= 1'b0;
      end else begin
         outst_q       <= outst_d;
         mac_valid_out <= accept;
         if (accept) begin
            first_q            <= in_last;
            mac_x_out          <= in_x;
            mac_y_out          <= in_y;
            mac_accumulate_out <= !first_q;
         end
      end
   end

   // Tag stage k lines up with the MAC op issued k cycles ago; stage LATENCY meets its result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
      end else begin
         tag_q[0].valid <= accept;
         tag_q[0].last  <= in_last;
         tag_q[0].count <= cnt_tag;
         for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
      end
   end

   assign fifo_wr           = tag_q[LATENCY].valid && tag_q[LATENCY].last;
   assign fifo_wdata.result = mac_result_in;
   assign fifo_wdata.count  = tag_q[LATENCY].count;

   kanagawa_dot_seq_result_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (fifo_wr),
      .in_ready  (fifo_ready_unused),
      .in_data   (fifo_wdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (fifo_rdata)
   );

   assign out_result = fifo_rdata.result;

endmodule

// File: tb/tb_kanagawa_dot_accum_sequencer.sv
// Directed bench: two sequencers (CNT_W=16 and CNT_W=2) each driving a behavioural fmac32 model.
module tb_kanagawa_dot_accum_sequencer;

   localparam int LAT = 4;
`ifdef KANAGAWA_DOT_SEQ_COUNT_EN
   localparam bit CE = 1'b1;
`else
   localparam bit CE = 1'b0;
`endif

   localparam logic [31:0] F0_5 = 32'h3F000000, F1 = 32'h3F800000, F2 = 32'h40000000,
                           F3 = 32'h40400000, F4 = 32'h40800000, F5 = 32'h40A00000,
                           F6 = 32'h40C00000, F7 = 32'h40E00000, F8 = 32'h41000000,
                           F16 = 32'h41800000, F25 = 32'h41C80000, FM1 = 32'hBF800000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iv [2], il [2], ir [2], mv [2], macc [2], ov [2], ordy [2];
   logic [31:0] ix [2], iy [2], mx [2], my [2], mres [2], ores [2];
   logic [15:0] oc0;
   logic [1:0]  oc1;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   kanagawa_dot_accum_sequencer #(.LATENCY(LAT), .OUT_DEPTH(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_x(ix[0]), .in_y(iy[0]),
      .in_last(il[0]), .mac_x_out(mx[0]), .mac_y_out(my[0]), .mac_accumulate_out(macc[0]),
      .mac_valid_out(mv[0]), .mac_result_in(mres[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_result(ores[0]), .out_count(oc0));

   kanagawa_dot_accum_sequencer #(.LATENCY(LAT), .OUT_DEPTH(2), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_x(ix[1]), .in_y(iy[1]),
      .in_last(il[1]), .mac_x_out(mx[1]), .mac_y_out(my[1]), .mac_accumulate_out(macc[1]),
      .mac_valid_out(mv[1]), .mac_result_in(mres[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_result(ores[1]), .out_count(oc1));

   function automatic real f2r(input logic [31:0] b);
      logic [10:0] e;
      if (b[30:0] == 31'd0) return 0.0;
      e = {3'b000, b[30:23]} + 11'd896;
      return $bitstoreal({b[31], e, b[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return 32'h0;
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // fmac32 model: synchronous reset, result LAT cycles after the op is presented.
   for (genvar g = 0; g < 2; g++) begin : g_mac
      real         acc_r;
      logic [31:0] pipe [LAT];
      always @(posedge clk) begin
         if (rst) begin
            acc_r <= 0.0;
            for (int i = 0; i < LAT; i++) pipe[i] <= 32'h0;
         end else begin
            if (mv[g]) begin
               acc_r   <= (macc[g] ? acc_r : 0.0) + f2r(mx[g]) * f2r(my[g]);
               pipe[0] <= r2f((macc[g] ? acc_r : 0.0) + f2r(mx[g]) * f2r(my[g]));
            end else begin
               pipe[0] <= 32'h0;
            end
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
         end
      end
      assign mres[g] = pipe[LAT-1];
   end

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic beat(input int s, input logic [31:0] x, input logic [31:0] y,
                       input logic last, input logic exp_acc);
      int w = 0;
      iv[s] = 1'b1; ix[s] = x; iy[s] = y; il[s] = last;
      while (!ir[s] && w < 50) begin @(negedge clk); w++; end
      n_tests++;
      if (!ir[s]) begin
         n_fail++;
         $display("FAIL beat_ready: in_ready=%0b after %0d cycles, need 1", ir[s], w);
      end
      @(posedge clk);
      @(negedge clk);
      iv[s] = 1'b0; il[s] = 1'b0;
      n_tests++;
      if (mv[s] !== 1'b1 || mx[s] !== x || my[s] !== y || macc[s] !== exp_acc) begin
         n_fail++;
         $display("FAIL beat_issue: valid=%0b x=%h y=%h acc=%0b, need 1 %h %h %0b",
                  mv[s], mx[s], my[s], macc[s], x, y, exp_acc);
      end
   endtask

   task automatic wait_ov(input int s, output int k);
      k = 0;
      while (!ov[s] && k < 40) begin @(negedge clk); k++; end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++;
      if (ir[0] !== 1'b0 || mv[0] !== 1'b0 || macc[0] !== 1'b0 || mx[0] !== 32'h0 ||
          my[0] !== 32'h0 || ov[0] !== 1'b0 || ores[0] !== 32'h0 || oc0 !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_state: ir=%0b mv=%0b acc=%0b x=%h y=%h ov=%0b res=%h cnt=%0d, need all 0",
                  ir[0], mv[0], macc[0], mx[0], my[0], ov[0], ores[0], oc0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (ir[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: in_ready=%0b, need 1", ir[0]);
      end
   endtask

   task automatic test_single();
      int k;
      ordy[0] = 1'b1;
      beat(0, F1, F2, 1'b0, 1'b0);
      beat(0, F3, F4, 1'b0, 1'b1);
      beat(0, F0_5, F8, 1'b0, 1'b1);
      beat(0, FM1, F2, 1'b1, 1'b1);
      wait_ov(0, k);
      n_tests++;
      if (k + 1 != 6) begin
         n_fail++;
         $display("FAIL single_latency: out_valid %0d cycles after last accept, need 6", k + 1);
      end
      n_tests++;
      if (ov[0] !== 1'b1 || ores[0] !== F16 || oc0 !== (CE ? 16'd4 : 16'd0)) begin
         n_fail++;
         $display("FAIL single_result: ov=%0b res=%h cnt=%0d, need 1 %h %0d",
                  ov[0], ores[0], oc0, F16, CE ? 4 : 0);
      end
      @(negedge clk);
      n_tests++;
      if (ov[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pop: out_valid=%0b after pop, need 0", ov[0]);
      end
   endtask

   task automatic test_back_to_back();
      int k;
      ordy[0] = 1'b1;
      beat(0, F2, F3, 1'b1, 1'b0);
      beat(0, F5, F5, 1'b1, 1'b0);
      wait_ov(0, k);
      n_tests++;
      if (ov[0] !== 1'b1 || ores[0] !== F6) begin
         n_fail++;
         $display("FAIL b2b_first: ov=%0b res=%h, need 1 %h", ov[0], ores[0], F6);
      end
      @(negedge clk);
      n_tests++;
      if (ov[0] !== 1'b1 || ores[0] !== F25) begin
         n_fail++;
         $display("FAIL b2b_second: ov=%0b res=%h, need 1 %h", ov[0], ores[0], F25);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int  k;
      bit  saw_ready = 1'b0;
      ordy[0] = 1'b0;
      beat(0, F1, F3, 1'b1, 1'b0);
      beat(0, F2, F2, 1'b1, 1'b0);
      n_tests++;
      if (ir[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_credit_drop: in_ready=%0b, need 0", ir[0]);
      end
      iv[0] = 1'b1; ix[0] = F1; iy[0] = F7; il[0] = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (ir[0] !== 1'b0) saw_ready = 1'b1;
      end
      n_tests++;
      if (saw_ready || ov[0] !== 1'b1 || ores[0] !== F3) begin
         n_fail++;
         $display("FAIL bp_stall: ready_seen=%0b ov=%0b res=%h, need 0 1 %h",
                  saw_ready, ov[0], ores[0], F3);
      end
      ordy[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ordy[0] = 1'b0;
      n_tests++;
      if (ir[0] !== 1'b1 || ov[0] !== 1'b1 || ores[0] !== F4) begin
         n_fail++;
         $display("FAIL bp_one_pop: ir=%0b ov=%0b res=%h, need 1 1 %h", ir[0], ov[0], ores[0], F4);
      end
      @(posedge clk);
      @(negedge clk);
      iv[0] = 1'b0; il[0] = 1'b0;
      n_tests++;
      if (mv[0] !== 1'b1 || mx[0] !== F1 || my[0] !== F7 || macc[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_third_issue: mv=%0b x=%h y=%h acc=%0b, need 1 %h %h 0",
                  mv[0], mx[0], my[0], macc[0], F1, F7);
      end
      ordy[0] = 1'b1;
      @(negedge clk);
      wait_ov(0, k);
      n_tests++;
      if (ov[0] !== 1'b1 || ores[0] !== F7) begin
         n_fail++;
         $display("FAIL bp_third_result: ov=%0b res=%h, need 1 %h", ov[0], ores[0], F7);
      end
      @(negedge clk);
   endtask

   task automatic test_simul_pop_accept();
      int k;
      ordy[0] = 1'b0;
      beat(0, F1, F3, 1'b1, 1'b0);
      wait_ov(0, k);
      n_tests++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_setup: ov=%0b ir=%0b, need 1 1", ov[0], ir[0]);
      end
      ordy[0] = 1'b1;
      iv[0] = 1'b1; ix[0] = F2; iy[0] = F2; il[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv[0] = 1'b0; il[0] = 1'b0; ordy[0] = 1'b0;
      n_tests++;
      if (ir[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_ready: in_ready=%0b after pop+last, need 1", ir[0]);
      end
      ordy[0] = 1'b1;
      wait_ov(0, k);
      n_tests++;
      if (ov[0] !== 1'b1 || ores[0] !== F4) begin
         n_fail++;
         $display("FAIL simul_result: ov=%0b res=%h, need 1 %h", ov[0], ores[0], F4);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int k;
      bit saw = 1'b0;
      ordy[0] = 1'b1;
      beat(0, F1, F1, 1'b0, 1'b0);
      beat(0, F2, F2, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      n_tests++;
      if (ir[0] !== 1'b0 || mv[0] !== 1'b0 || macc[0] !== 1'b0 || mx[0] !== 32'h0 ||
          my[0] !== 32'h0 || ov[0] !== 1'b0 || ores[0] !== 32'h0 || oc0 !== 16'h0) begin
         n_fail++;
         $display("FAIL midreset_state: ir=%0b mv=%0b acc=%0b x=%h y=%h ov=%0b res=%h cnt=%0d, need all 0",
                  ir[0], mv[0], macc[0], mx[0], my[0], ov[0], ores[0], oc0);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (ov[0] !== 1'b0) saw = 1'b1;
      end
      n_tests++;
      if (saw) begin
         n_fail++;
         $display("FAIL midreset_no_result: out_valid seen=1, need 0");
      end
      beat(0, F1, F1, 1'b1, 1'b0);
      wait_ov(0, k);
      n_tests++;
      if (ov[0] !== 1'b1 || ores[0] !== F1 || oc0 !== (CE ? 16'd1 : 16'd0)) begin
         n_fail++;
         $display("FAIL midreset_after: ov=%0b res=%h cnt=%0d, need 1 %h %0d",
                  ov[0], ores[0], oc0, F1, CE ? 1 : 0);
      end
      @(negedge clk);
   endtask

   task automatic test_saturate();
      int k;
      ordy[1] = 1'b1;
      beat(1, F1, F1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) beat(1, F1, F1, 1'b0, 1'b1);
      beat(1, F1, F1, 1'b1, 1'b1);
      wait_ov(1, k);
      n_tests++;
      if (ov[1] !== 1'b1 || ores[1] !== F5 || oc1 !== (CE ? 2'd3 : 2'd0)) begin
         n_fail++;
         $display("FAIL sat_count: ov=%0b res=%h cnt=%0d, need 1 %h %0d",
                  ov[1], ores[1], oc1, F5, CE ? 3 : 0);
      end
      @(negedge clk);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         iv[s] = 1'b0; il[s] = 1'b0; ix[s] = 32'h0; iy[s] = 32'h0; ordy[s] = 1'b0;
      end
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_simul_pop_accept();
      test_reset_mid();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, need completion");
      $fatal(1, "watchdog");
   end

endmodule
